// File: rtl/avalon_ram_model.sv
// Avalon-MM slave RAM model for CPU benches: configurable wait states (fixed or LFSR-random),
// byte-enable writes, clocked preload port, sticky error flag and a transaction counter.
module avalon_ram_model #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_CYCLES = 2,
  parameter int          WAIT_MODE   = 0,
  localparam int         AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   address,
  input  logic          read,
  input  logic          write,
  input  logic [31:0]   writedata,
  input  logic [3:0]    byteenable,
  output logic          waitrequest,
  output logic [31:0]   readdata,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  output logic          err,
  output logic [15:0]   txn_count
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);
  localparam logic [7:0]  WMOD = 8'(WAIT_CYCLES + 1);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   readdata_q, readdata_d;
  logic          err_q, err_d;
  logic [15:0]   txn_q, txn_d;
  logic [7:0]    lfsr_q, lfsr_d;

  logic          req;
  logic          addr_ok;
  logic          bad;
  logic          wr_commit;
  logic [31:0]   offset;
  logic [AW-1:0] idx;
  logic [31:0]   mem_rd;
  logic [31:0]   ack_data;
  logic [3:0]    n_wait;

  assign req      = read | write;
  assign offset   = address - BASE_ADDR;
  assign addr_ok  = (address >= BASE_ADDR) && (offset < SPAN) && (address[1:0] == 2'b00);
  assign bad      = !addr_ok || (read && write);
  assign idx      = offset[AW+1:2];
  assign ack_data = bad ? 32'hDEAD_BEEF : mem_rd;
  assign n_wait   = (WAIT_MODE == 1) ? 4'(lfsr_q % WMOD) : 4'(WAIT_CYCLES);

  assign waitrequest = req && (state_q != S_ACK);
  assign readdata    = readdata_q;
  assign err         = err_q;
  assign txn_count   = txn_q;

  // Bus writes land on the edge that leaves ACK, with the master still holding its inputs.
  assign wr_commit = (state_q == S_ACK) && write && !bad;

  // One byte-wide array per lane keeps byte-enable writes a plain single-port RAM.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH_WORDS];

      // Preload wins if it collides with a bus write.
      always_ff @(posedge clk) begin
        if (load_en) begin
          mem[load_addr] <= load_data[8*gi +: 8];
        end else if (wr_commit && byteenable[gi]) begin
          mem[idx] <= writedata[8*gi +: 8];
        end
      end

      assign mem_rd[8*gi +: 8] = mem[idx];
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    readdata_d = readdata_q;
    err_d      = err_q;
    txn_d      = txn_q;
    lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    case (state_q)
      S_IDLE: begin
        if (req && !load_en) begin
          cnt_d = n_wait;
          if (n_wait != 4'd0) begin
            state_d = S_WAIT;
          end else begin
            state_d    = S_ACK;
            readdata_d = ack_data;
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          // Master abandoned the request mid-stall: protocol violation.
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_d    = S_ACK;
            readdata_d = ack_data;
          end
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
        txn_d   = txn_q + 16'd1;
        if (bad) begin
          err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      readdata_q <= 32'd0;
      err_q      <= 1'b0;
      txn_q      <= 16'd0;
      lfsr_q     <= 8'hA5;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      readdata_q <= readdata_d;
      err_q      <= err_d;
      txn_q      <= txn_d;
      lfsr_q     <= lfsr_d;
    end
  end

endmodule

// File: tb/tb_avalon_ram_model.sv
// Directed bench for avalon_ram_model: a fixed-wait instance driven from a vector table plus
// hand-written corner sequences, and a random-wait instance with a non-zero base address.
module tb_avalon_ram_model;

  logic        clk = 1'b0;
  logic        reset;

  logic [31:0] address, writedata, readdata, load_data;
  logic        read, write, waitrequest, load_en, err;
  logic [3:0]  byteenable;
  logic [7:0]  load_addr;
  logic [15:0] txn_count;

  logic [31:0] address2, writedata2, readdata2, load_data2;
  logic        read2, write2, waitrequest2, load_en2, err2;
  logic [3:0]  byteenable2;
  logic [7:0]  load_addr2;
  logic [15:0] txn_count2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  avalon_ram_model #(
    .BASE_ADDR(32'h0000_0000), .DEPTH_WORDS(256), .WAIT_CYCLES(2), .WAIT_MODE(0)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .waitrequest(waitrequest),
    .readdata(readdata), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .err(err), .txn_count(txn_count)
  );

  avalon_ram_model #(
    .BASE_ADDR(32'h1000_0000), .DEPTH_WORDS(256), .WAIT_CYCLES(3), .WAIT_MODE(1)
  ) dut2 (
    .clk(clk), .reset(reset), .address(address2), .read(read2), .write(write2),
    .writedata(writedata2), .byteenable(byteenable2), .waitrequest(waitrequest2),
    .readdata(readdata2), .load_en(load_en2), .load_addr(load_addr2), .load_data(load_data2),
    .err(err2), .txn_count(txn_count2)
  );

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        chk;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Inputs are already driven at the current falling edge; counts stalled cycles up to the ACK.
  task automatic await_ack(output int hi, output logic [31:0] rd);
    logic acked;
    hi = 0; rd = 32'h0; acked = 1'b0;
    for (int k = 0; k < 64; k++) begin
      #1;
      if (!waitrequest) begin
        rd = readdata; acked = 1'b1;
        break;
      end
      hi++;
      @(negedge clk);
    end
    if (!acked) begin
      tests++; fails++;
      $display("FAIL ack_timeout: got no ACK within 64 cycles, expected one");
    end
    @(negedge clk);
    read = 1'b0; write = 1'b0;
    #1;
  endtask

  task automatic bus(input logic rd_i, input logic wr_i, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] be,
                     output int hi, output logic [31:0] rdata);
    @(negedge clk);
    read = rd_i; write = wr_i; address = a; writedata = wd; byteenable = be;
    await_ack(hi, rdata);
    $display("[TB] txn rd=%b wr=%b addr=%08h wd=%08h be=%b -> stall=%0d rdata=%08h err=%b cnt=%0d",
             rd_i, wr_i, a, wd, be, hi, rdata, err, txn_count);
  endtask

  task automatic bus2(input logic [31:0] a, output int hi, output logic [31:0] rdata, output logic acked);
    @(negedge clk);
    read2 = 1'b1; address2 = a;
    hi = 0; rdata = 32'h0; acked = 1'b0;
    for (int k = 0; k < 16; k++) begin
      #1;
      if (!waitrequest2) begin
        rdata = readdata2; acked = 1'b1;
        break;
      end
      hi++;
      @(negedge clk);
    end
    @(negedge clk);
    read2 = 1'b0;
    #1;
    $display("[TB] txn2 addr=%08h -> stall=%0d rdata=%08h err=%b cnt=%0d", a, hi, rdata, err2, txn_count2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          hi;
    int          exp_txn;
    logic [31:0] rdv;
    logic        acked;
    logic [15:0] seen;

    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,          4'h0, 1'b1, 32'h2402_0010, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h1122_3344,  4'h5, 1'b0, 32'h0,          1'b0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,          4'h0, 1'b1, 32'hFF22_FF44, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_0014, 32'hAABB_CCDD,  4'hF, 1'b0, 32'h0,          1'b0};
    vecs[4]  = '{1'b0, 1'b1, 32'h0000_0014, 32'h1234_5678,  4'h0, 1'b0, 32'h0,          1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_0014, 32'h0,          4'h0, 1'b1, 32'hAABB_CCDD, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 32'h0000_0014, 32'h9900_0000,  4'h8, 1'b0, 32'h0,          1'b0};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_0014, 32'h0,          4'h0, 1'b1, 32'h99BB_CCDD, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,          4'h0, 1'b1, 32'h0123_4567, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_0402, 32'h0,          4'h0, 1'b1, 32'hDEAD_BEEF, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_0400, 32'h0,          4'h0, 1'b1, 32'hDEAD_BEEF, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,          4'h0, 1'b1, 32'hFF22_FF44, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 32'h0000_0400, 32'h0,          4'hF, 1'b0, 32'h0,          1'b1};
    vecs[13] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,          4'h0, 1'b1, 32'h0123_4567, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 32'h0000_03FC, 32'h5555_AAAA,  4'hF, 1'b0, 32'h0,          1'b1};
    vecs[15] = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0,          4'h0, 1'b1, 32'h5555_AAAA, 1'b1};
    vecs[16] = '{1'b1, 1'b1, 32'h0000_0004, 32'h0,          4'hF, 1'b1, 32'hDEAD_BEEF, 1'b1};
    vecs[17] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,          4'h0, 1'b1, 32'h2402_0010, 1'b1};
    vecs[18] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,          4'h0, 1'b1, 32'hDEAD_BEEF, 1'b1};

    reset = 1'b0;
    read = 1'b1; write = 1'b0; address = 32'h0; writedata = 32'h0; byteenable = 4'h0;
    load_en = 1'b0; load_addr = 8'h0; load_data = 32'h0;
    read2 = 1'b0; write2 = 1'b0; address2 = 32'h0; writedata2 = 32'h0; byteenable2 = 4'h0;
    load_en2 = 1'b0; load_addr2 = 8'h0; load_data2 = 32'h0;

    // Reset values, and waitrequest following req while in reset.
    #2;
    chk32("rst_wreq_req", 32'(waitrequest), 32'd1);
    read = 1'b0;
    #1;
    chk32("rst_wreq_idle", 32'(waitrequest), 32'd0);
    chk32("rst_readdata", readdata, 32'h0);
    chk32("rst_err", 32'(err), 32'd0);
    chk32("rst_txn", 32'(txn_count), 32'd0);
    chk32("rst_txn2", 32'(txn_count2), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    preload(8'd0, 32'h0123_4567);
    preload(8'd1, 32'h2402_0010);
    preload(8'd2, 32'hCAFE_0002);
    preload(8'd4, 32'hFFFF_FFFF);

    exp_txn = 0;
    for (int i = 0; i < NVEC; i++) begin
      bus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].be, hi, rdv);
      exp_txn++;
      chk32($sformatf("vec%0d_stall", i), 32'(hi), 32'd3);
      if (vecs[i].chk) chk32($sformatf("vec%0d_rdata", i), rdv, vecs[i].exp_rd);
      chk32($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
      chk32($sformatf("vec%0d_txn", i), 32'(txn_count), 32'(exp_txn));
    end

    // Preload held for 3 cycles under a pending read of the same word.
    @(negedge clk);
    read = 1'b1; address = 32'h0000_001C;
    load_en = 1'b1; load_addr = 8'd7; load_data = 32'h7777_0007;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk32($sformatf("load_hold_wreq%0d", k), 32'(waitrequest), 32'd1);
      @(negedge clk);
    end
    load_en = 1'b0;
    await_ack(hi, rdv);
    exp_txn++;
    $display("[TB] txn load-overlap read addr=0000001c -> stall=%0d rdata=%08h", hi, rdv);
    chk32("load_after_stall", 32'(hi), 32'd3);
    chk32("load_after_rdata", rdv, 32'h7777_0007);
    chk32("load_after_txn", 32'(txn_count), 32'(exp_txn));

    // Reset asserted while a write to 0x8 is stalled in WAIT.
    @(negedge clk);
    write = 1'b1; address = 32'h0000_0008; writedata = 32'h0; byteenable = 4'hF;
    #1;
    chk32("rstmid_wreq_idle", 32'(waitrequest), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    $display("[TB] txn write addr=00000008 aborted by reset");
    chk32("rstmid_readdata", readdata, 32'h0);
    chk32("rstmid_txn", 32'(txn_count), 32'd0);
    chk32("rstmid_err", 32'(err), 32'd0);
    chk32("rstmid_wreq", 32'(waitrequest), 32'd1);
    @(negedge clk);
    write = 1'b0; reset = 1'b1;
    exp_txn = 0;
    bus(1'b1, 1'b0, 32'h0000_0008, 32'h0, 4'h0, hi, rdv);
    exp_txn++;
    chk32("rstmid_mem2", rdv, 32'hCAFE_0002);
    chk32("rstmid_stall", 32'(hi), 32'd3);
    chk32("rstmid_txn_after", 32'(txn_count), 32'(exp_txn));

    // Master drops the write while it is stalled in WAIT.
    @(negedge clk);
    write = 1'b1; address = 32'h0000_0008; writedata = 32'h0; byteenable = 4'hF;
    @(negedge clk);
    write = 1'b0;
    @(negedge clk);
    #1;
    $display("[TB] txn write addr=00000008 abandoned in WAIT -> err=%b cnt=%0d", err, txn_count);
    chk32("drop_err", 32'(err), 32'd1);
    chk32("drop_txn", 32'(txn_count), 32'(exp_txn));
    chk32("drop_wreq", 32'(waitrequest), 32'd0);
    bus(1'b1, 1'b0, 32'h0000_0008, 32'h0, 4'h0, hi, rdv);
    exp_txn++;
    chk32("drop_mem2", rdv, 32'hCAFE_0002);
    chk32("drop_stall", 32'(hi), 32'd3);

    // Random-wait instance at base 0x1000_0000.
    @(negedge clk);
    load_en2 = 1'b1; load_addr2 = 8'd0; load_data2 = 32'h5A5A_0000;
    @(negedge clk);
    load_en2 = 1'b0;
    seen = 16'h0;
    for (int i = 0; i < 200; i++) begin
      bus2(32'h1000_0000, hi, rdv, acked);
      tests++;
      if (!acked || hi < 1 || hi > 4) begin
        fails++;
        $display("FAIL rand_stall%0d: got %0d cycles (acked=%b), expected 1..4", i, hi, acked);
      end
      if (hi < 16) seen[hi] = 1'b1;
      chk32($sformatf("rand_rdata%0d", i), rdv, 32'h5A5A_0000);
    end
    chk32("rand_distinct_gt1", 32'($countones(seen) > 1), 32'd1);
    chk32("rand_txn", 32'(txn_count2), 32'd200);
    chk32("rand_err", 32'(err2), 32'd0);
    bus2(32'h0FFF_FFFC, hi, rdv, acked);
    chk32("below_base_rdata", rdv, 32'hDEAD_BEEF);
    chk32("below_base_err", 32'(err2), 32'd1);
    chk32("below_base_txn", 32'(txn_count2), 32'd201);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/avalon_ram_model.md
# avalon_ram_model

Parametrised Avalon-MM slave memory for CPU testbenches. It replaces fixed-latency RAM models with configurable depth, base address and wait-state behaviour, which can be fixed or pseudo-random. It also provides a clocked preload port, byte-enable writes, error flagging and a transaction counter. It sits between `top_level_cpu` (bus master) and the testbench stimulus that loads program images.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0.
- `DEPTH_WORDS`, default 256: memory depth in 32-bit words. Power of two, 4..65536.
- `WAIT_CYCLES`, default 2: extra wait cycles per transaction. Fixed count in mode 0, maximum in mode 1. Range 0..15.
- `WAIT_MODE`, default 0: 0 = fixed wait, 1 = LFSR-random wait in 0..WAIT_CYCLES.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `address`  in  32  byte address from master.
- `read`  in  1  read request.
- `write`  in  1  write request.
- `writedata`  in  32  write data.
- `byteenable`  in  4  byte lanes for writes; bit i selects bits 8i+7:8i.
- `waitrequest`  out  1  stall; master holds request and inputs while high.
- `readdata`  out  32  read data, valid in the cycle waitrequest is low.
- `load_en`  in  1  preload strobe.
- `load_addr`  in  log2(DEPTH_WORDS)  preload word index.
- `load_data`  in  32  preload word.
- `err`  out  1  sticky protocol/decode error flag.
- `txn_count`  out  16  completed bus transactions, wraps.

## Operation
- FSM states: IDLE, WAIT, ACK.
- `req` = read | write.
- `waitrequest` = req && (state != ACK). It is combinational from state and inputs.
- IDLE:
  - If req and not load_en: latch N into a 4-bit counter. Go to WAIT if N > 0, else ACK.
  - If load_en: stay in IDLE; waitrequest stays high.
- WAIT:
  - Decrement the counter; go to ACK when the counter reaches 1.
  - If req drops: go to IDLE, set err, no write.
- ACK: one cycle, waitrequest low.
  - Read: readdata = mem[idx].
  - Write: for each set byteenable bit, update that lane of mem[idx] at the end of the cycle.
  - txn_count increments by 1.
  - Next state is IDLE.
- Decode:
  - idx = (address − BASE_ADDR) >> 2.
  - The address is valid iff address ≥ BASE_ADDR, offset < 4·DEPTH_WORDS, and address[1:0] == 0.
- Invalid address, or read && write together:
  - The transaction still completes normally through ACK.
  - No memory change; readdata = 32'hDEAD_BEEF; err set.
- byteenable == 0 on a write: acknowledged, no change, no error.
- Preload:
  - When load_en is high, mem[load_addr] ← load_data on the clock edge.
  - Preload has priority; the bus FSM holds in IDLE while load_en is high.
- Wait source:
  - WAIT_MODE 0: N = WAIT_CYCLES.
  - WAIT_MODE 1: N = lfsr[7:0] mod (WAIT_CYCLES+1).
  - The LFSR is 8-bit Fibonacci, taps 8,6,5,4, and advances every clock.
- err clears only on reset.
- Memory contents are unaffected by reset.

## Timing
- Reset values (async, while reset = 0):
  - state IDLE, counter 0, readdata 0, err 0, txn_count 0, LFSR 8'hA5.
  - waitrequest follows its equation: high if req is asserted.
- Transaction length:
  - Request seen in cycle 0 (waitrequest 1).
  - Cycles 1..N in WAIT (waitrequest 1).
  - Cycle N+1 in ACK (waitrequest 0).
  - Total N+2 cycles, of which N+1 have waitrequest high.
- readdata is registered on entry to ACK and holds its value until the next ACK.
- Back-to-back: if req is still high in the cycle after ACK, IDLE starts a new transaction. Minimum two cycles per transaction.
- Preload-then-read of the same word: the read sees the new value. The FSM cannot reach ACK in the same cycle as the preload edge.
- Reset mid-transaction: abort to IDLE, no write commit, counter unchanged from its reset value.
- txn_count wraps 16'hFFFF → 16'h0000.

## Test plan
- Preload mem[1]=32'h2402_0010 via load_en. Read 32'h0000_0004, WAIT_CYCLES=2, mode 0 → waitrequest high for exactly 3 cycles; readdata 32'h2402_0010 in the 4th; txn_count=1.
- Write 32'h1122_3344 to 32'h10 with byteenable 4'b0101 over prior 32'hFFFF_FFFF, then read back → 32'hFF22_FF44; err=0.
- Read 32'h0000_0402 (misaligned), then 32'h0000_0400 (out of range at DEPTH 256) → both return 32'hDEAD_BEEF; err=1 and stays 1; memory unchanged.
- Assert load_en for 3 cycles while read is pending → waitrequest high throughout; ACK occurs N+1 cycles after load_en falls.
- Drop reset (low) during WAIT of a write to 32'h8 → state IDLE, mem[2] unchanged, readdata=0, txn_count=0, err=0.
- WAIT_MODE=1, WAIT_CYCLES=3, 200 sequential reads → every waitrequest-high run lasts 1..4 cycles; more than one distinct length observed; txn_count=200.
